// File: rtl/ooo_result_engine_if.sv
// Request/retire bus of the out-of-order result engine.
// The master side issues requests; the slave side reports retired tags.
interface ooo_result_engine_if #(
   parameter int LAT_W = 3
);
   logic             vld_i;
   logic [LAT_W-1:0] in_lat;
   logic             in_rdy;
   logic             vld_o;
   logic [3:0]       result;
   logic [4:0]       occ;
   logic             drop;

   modport master (
      output vld_i, in_lat,
      input  in_rdy, vld_o, result, occ, drop
   );

   modport slave (
      input  vld_i, in_lat,
      output in_rdy, vld_o, result, occ, drop
   );
endinterface

// File: rtl/ooo_result_engine.sv
// Out-of-order completion engine: tags requests from a wrapping counter, holds
// each in a slot for its latency and retires the lowest-index ready slot per edge.
module ooo_result_engine #(
   parameter int DEPTH = 8,
   parameter int LAT_W = 3
) (
   input logic                 clk,
   input logic                 rst,
   ooo_result_engine_if.slave  bus
);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0]            slot_vld;
   logic [DEPTH-1:0][3:0]       slot_tag;
   logic [DEPTH-1:0][LAT_W-1:0] slot_cnt;
   logic [3:0]                  tag_ctr;

   logic [DEPTH-1:0] elig;
   logic             ret_any;
   logic [IW-1:0]    ret_idx;
   logic [IW-1:0]    free_idx;
   logic             rdy;
   logic             accept;

   logic       vld_q;
   logic [3:0] result_q;
   logic [4:0] occ_q;
   logic       drop_q;

   // Reverse scans leave the lowest matching index as the winner.
   always_comb begin
      ret_any  = 1'b0;
      ret_idx  = '0;
      free_idx = '0;
      for (int i = 0; i < DEPTH; i++)
         elig[i] = slot_vld[i] && (slot_cnt[i] == '0);
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (elig[i]) begin
            ret_any = 1'b1;
            ret_idx = IW'(i);
         end
         if (!slot_vld[i])
            free_idx = IW'(i);
      end
   end

   assign rdy    = ~&slot_vld;
   assign accept = bus.vld_i & rdy;

   // Allocation reads pre-edge slot_vld, so a retiring slot is never the free one.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_vld <= '0;
         slot_tag <= '0;
         slot_cnt <= '0;
         tag_ctr  <= '0;
         vld_q    <= 1'b0;
         result_q <= '0;
         occ_q    <= '0;
         drop_q   <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (slot_vld[i] && (slot_cnt[i] != '0))
               slot_cnt[i] <= slot_cnt[i] - 1'b1;
         if (ret_any)
            slot_vld[ret_idx] <= 1'b0;
         if (accept) begin
            slot_vld[free_idx] <= 1'b1;
            slot_tag[free_idx] <= tag_ctr;
            slot_cnt[free_idx] <= bus.in_lat;
            tag_ctr            <= tag_ctr + 4'd1;
         end
         vld_q <= ret_any;
         if (ret_any)
            result_q <= slot_tag[ret_idx];
         occ_q  <= occ_q + 5'(accept) - 5'(ret_any);
         drop_q <= bus.vld_i & ~rdy;
      end
   end

   assign bus.in_rdy = rdy;
   assign bus.vld_o  = vld_q;
   assign bus.result = result_q;
   assign bus.occ    = occ_q;
   assign bus.drop   = drop_q;
endmodule

// File: tb/tb_ooo_result_engine.sv
// Bench for ooo_result_engine: per-cycle comparison against a ready-time model
// plus directed scenarios with hand-computed retire tags and timings.
module tb_ooo_result_engine;
   localparam int DEPTH = 8;
   localparam int LAT_W = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ooo_result_engine_if #(.LAT_W(LAT_W)) bus();

   ooo_result_engine #(.DEPTH(DEPTH), .LAT_W(LAT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: each request remembers the absolute edge from which it may retire.
   bit mv     [DEPTH];
   int mready [DEPTH];
   int mtag   [DEPTH];
   int mtagctr, ecnt;
   bit m_ok = 1'b0;
   bit e_vld, e_drop;
   int e_res, e_occ;

   always @(posedge clk) begin
      int  r, a, n;
      bit  full;
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
         mtagctr = 0; ecnt = 0;
         e_vld = 1'b0; e_drop = 1'b0; e_res = 0; e_occ = 0;
         m_ok = 1'b1;
      end else if (m_ok) begin
         ecnt++;
         r = -1; a = -1; full = 1'b1;
         for (int i = 0; i < DEPTH; i++)
            if (r < 0 && mv[i] && mready[i] <= ecnt) r = i;
         for (int i = 0; i < DEPTH; i++)
            if (!mv[i]) begin
               full = 1'b0;
               if (a < 0) a = i;
            end
         e_drop = bus.vld_i && full;
         e_vld  = (r >= 0);
         if (r >= 0) begin
            e_res = mtag[r];
            mv[r] = 1'b0;
         end
         if (bus.vld_i && !full) begin
            mv[a]     = 1'b1;
            mtag[a]   = mtagctr;
            mready[a] = ecnt + int'(bus.in_lat) + 1;
            mtagctr   = (mtagctr + 1) % 16;
         end
         n = 0;
         for (int i = 0; i < DEPTH; i++) n += int'(mv[i]);
         e_occ = n;
      end
   end

   always @(negedge clk) begin
      bit full;
      if (m_ok) begin
         full = 1'b1;
         for (int i = 0; i < DEPTH; i++) if (!mv[i]) full = 1'b0;
         chk("model_vld_o", 32'(bus.vld_o), 32'(e_vld));
         if (e_vld) chk("model_result", 32'(bus.result), 32'(e_res));
         chk("model_occ", 32'(bus.occ), 32'(e_occ));
         chk("model_drop", 32'(bus.drop), 32'(e_drop));
         chk("model_in_rdy", 32'(bus.in_rdy), 32'(!full));
      end
   end

   task automatic step(input bit v, input int lat);
      bus.vld_i  = v;
      bus.in_lat = LAT_W'(lat);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b0, 0);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus.vld_i = 1'b0;
      bus.in_lat = '0;
      do_reset();
      chk("reset_vld_o", 32'(bus.vld_o), 0);
      chk("reset_result", 32'(bus.result), 0);
      chk("reset_occ", 32'(bus.occ), 0);
      chk("reset_drop", 32'(bus.drop), 0);
      chk("reset_in_rdy", 32'(bus.in_rdy), 1);

      // single request, zero latency
      step(1'b1, 0);
      chk("single_occ1", 32'(bus.occ), 1);
      chk("single_novld", 32'(bus.vld_o), 0);
      step(1'b0, 0);
      chk("single_vld", 32'(bus.vld_o), 1);
      chk("single_result", 32'(bus.result), 0);
      chk("single_occ0", 32'(bus.occ), 0);
      step(1'b0, 0);
      chk("single_pulse_end", 32'(bus.vld_o), 0);
      chk("single_result_hold", 32'(bus.result), 0);

      // reorder: tag1 overtakes tag0
      do_reset();
      step(1'b1, 5);
      step(1'b1, 0);
      step(1'b0, 0);
      chk("reorder_first", 32'(bus.result), 1);
      chk("reorder_first_vld", 32'(bus.vld_o), 1);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 0);
         chk("reorder_gap", 32'(bus.vld_o), 0);
      end
      step(1'b0, 0);
      chk("reorder_second", 32'(bus.result), 0);
      chk("reorder_second_vld", 32'(bus.vld_o), 1);

      // contention: both eligible together, lower slot first
      do_reset();
      step(1'b1, 3);
      step(1'b1, 2);
      step(1'b0, 0);
      step(1'b0, 0);
      chk("cont_quiet", 32'(bus.vld_o), 0);
      step(1'b0, 0);
      chk("cont_first", 32'(bus.result), 0);
      chk("cont_first_vld", 32'(bus.vld_o), 1);
      step(1'b0, 0);
      chk("cont_second", 32'(bus.result), 1);
      chk("cont_second_vld", 32'(bus.vld_o), 1);

      // full: eight long requests, then a dropped one
      do_reset();
      for (int k = 0; k < 8; k++) step(1'b1, 7);
      chk("full_occ", 32'(bus.occ), 8);
      chk("full_in_rdy", 32'(bus.in_rdy), 0);
      step(1'b1, 0);
      chk("full_drop", 32'(bus.drop), 1);
      chk("full_retire0", 32'(bus.result), 0);
      chk("full_rdy_back", 32'(bus.in_rdy), 1);
      step(1'b1, 0);
      chk("full_no_drop", 32'(bus.drop), 0);
      chk("full_retire1", 32'(bus.result), 1);
      chk("full_occ_steady", 32'(bus.occ), 7);
      step(1'b0, 0);
      chk("full_new_tag8", 32'(bus.result), 8);
      for (int k = 0; k < 10; k++) step(1'b0, 0);
      chk("full_drained", 32'(bus.occ), 0);

      // tag wrap: 20 zero-latency requests back to back
      do_reset();
      for (int j = 1; j <= 21; j++) begin
         step(j <= 20, 0);
         chk("wrap_drop", 32'(bus.drop), 0);
         if (j >= 2) begin
            chk("wrap_vld", 32'(bus.vld_o), 1);
            chk("wrap_result", 32'(bus.result), 32'((j - 2) % 16));
         end
      end

      // reset mid-flight, with a request presented on the reset edge
      do_reset();
      for (int k = 0; k < 5; k++) step(1'b1, 7);
      chk("rst_occ5", 32'(bus.occ), 5);
      rst = 1'b1;
      step(1'b1, 0);
      rst = 1'b0;
      chk("rst_occ0", 32'(bus.occ), 0);
      chk("rst_in_rdy", 32'(bus.in_rdy), 1);
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 0);
         chk("rst_no_retire", 32'(bus.vld_o), 0);
      end
      step(1'b1, 0);
      step(1'b0, 0);
      chk("rst_next_vld", 32'(bus.vld_o), 1);
      chk("rst_next_tag0", 32'(bus.result), 0);
      step(1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
